wb_regfile: RTL and testbench

Architectural register file at the end of the pipeline: it consumes the writeback-stage outputs (write enable, destination register, result data) and commits them, and serves the two decode-stage read ports with same-cycle write-through bypass. A host access port with a four-phase request/acknowledge handshake gives software read/write access to any register. Pipeline writeback always has priority over host writes.

---
 rtl/wb_regfile_pkg.sv | 17 +
 rtl/regfile_host_port.sv | 106 ++++++++++
 rtl/wb_regfile.sv | 76 +++++++
 tb/tb_wb_regfile.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared constants and host FSM state type for wb_regfile
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 3;
    localparam int CNT_W_DEF  = 32;

    // Register-index width of the core; the default host/pipeline address width.
    localparam int REG_IDX_W = ADDR_W_DEF;

    typedef enum logic [1:0] {
        HOST_IDLE = 2'd0,
        HOST_EXEC = 2'd1,
        HOST_DONE = 2'd2
    } host_state_t;

endpackage

// File: rtl/regfile_host_port.sv
// rtl/regfile_host_port.sv - host request/acknowledge port: FSM, capture regs, ack and read data
module regfile_host_port
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = REG_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              wreg_en_wb,
    input  logic [DATA_W-1:0] rd_val,
    output logic [ADDR_W-1:0] cap_addr,
    output logic              hw_en,
    output logic [DATA_W-1:0] hw_data,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata
);

    host_state_t       state_q;
    host_state_t       state_d;
    logic              cap_we_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [DATA_W-1:0] cap_wdata_q;
    logic              cap_en;
    logic              ack_set;
    logic              ack_clr;
    logic              rdata_en;

    assign cap_addr = cap_addr_q;
    assign hw_data  = cap_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Host writes yield to any pipeline writeback, regardless of address.
    always_comb begin
        state_d  = state_q;
        cap_en   = 1'b0;
        ack_set  = 1'b0;
        ack_clr  = 1'b0;
        rdata_en = 1'b0;
        hw_en    = 1'b0;
        case (state_q)
            HOST_IDLE: begin
                if (host_req) begin
                    cap_en  = 1'b1;
                    state_d = HOST_EXEC;
                end
            end
            HOST_EXEC: begin
                if (!cap_we_q) begin
                    rdata_en = 1'b1;
                    ack_set  = 1'b1;
                    state_d  = HOST_DONE;
                end else if (!wreg_en_wb) begin
                    hw_en   = 1'b1;
                    ack_set = 1'b1;
                    state_d = HOST_DONE;
                end
            end
            HOST_DONE: begin
                if (!host_req) begin
                    ack_clr = 1'b1;
                    state_d = HOST_IDLE;
                end
            end
            default: begin
                state_d = HOST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
        end else begin
            if (cap_en) begin
                cap_we_q    <= host_we;
                cap_addr_q  <= host_addr;
                cap_wdata_q <= host_wdata;
            end
            if (ack_set) begin
                host_ack <= 1'b1;
            end else if (ack_clr) begin
                host_ack <= 1'b0;
            end
            if (rdata_en) begin
                host_rdata <= rd_val;
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - architectural register file with writeback bypass and host access port
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = REG_IDX_W,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wreg_en_wb,
    input  logic [ADDR_W-1:0] wreg_addr_wb,
    input  logic [DATA_W-1:0] wdata_wb,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [CNT_W-1:0]  wb_count
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] host_cap_addr;
    logic              host_wr_en;
    logic [DATA_W-1:0] host_wr_data;
    logic [DATA_W-1:0] host_rd_val;

    // Same-cycle write-through: a writeback in flight is visible on every read path.
    assign rdata1      = (wreg_en_wb && (wreg_addr_wb == raddr1)) ? wdata_wb : regs[raddr1];
    assign rdata2      = (wreg_en_wb && (wreg_addr_wb == raddr2)) ? wdata_wb : regs[raddr2];
    assign host_rd_val = (wreg_en_wb && (wreg_addr_wb == host_cap_addr)) ? wdata_wb
                                                                          : regs[host_cap_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else begin
            if (wreg_en_wb) begin
                regs[wreg_addr_wb] <= wdata_wb;
                wb_count           <= wb_count + CNT_W'(1);
            end else if (host_wr_en) begin
                regs[host_cap_addr] <= host_wr_data;
            end
        end
    end

    regfile_host_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_host_port (
        .clk        (clk),
        .rst        (rst),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .wreg_en_wb (wreg_en_wb),
        .rd_val     (host_rd_val),
        .cap_addr   (host_cap_addr),
        .hw_en      (host_wr_en),
        .hw_data    (host_wr_data),
        .host_ack   (host_ack),
        .host_rdata (host_rdata)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile
module tb_wb_regfile;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wreg_en_wb;
    logic [ADDR_W-1:0] wreg_addr_wb;
    logic [DATA_W-1:0] wdata_wb;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic [CNT_W-1:0]  wb_count;

    wb_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wreg_en_wb   (wreg_en_wb),
        .wreg_addr_wb (wreg_addr_wb),
        .wdata_wb     (wdata_wb),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .wb_count     (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
        int          cyc;
    } chk_t;

    typedef struct {
        string       name;
        int          cyc;
        bit          chk_rd;
        logic [63:0] exp;
    } ack_t;

    localparam int SEL_RDATA1  = 0;
    localparam int SEL_RDATA2  = 1;
    localparam int SEL_COUNT   = 2;
    localparam int SEL_ACK     = 3;
    localparam int SEL_HRDATA  = 4;
    localparam int SEL_TIMEOUT = 99;

    chk_t chk_q[$];
    ack_t ack_q[$];
    int   cyc = 0;
    bit   done = 1'b0;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [63:0] pick(int sel);
        case (sel)
            SEL_RDATA1: pick = rdata1;
            SEL_RDATA2: pick = rdata2;
            SEL_COUNT:  pick = {60'd0, wb_count};
            SEL_ACK:    pick = {63'd0, host_ack};
            SEL_HRDATA: pick = host_rdata;
            default:    pick = '0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops expectations as the DUT presents outputs, on the falling edge.
    initial begin
        chk_t c;
        ack_t a;
        bit   ack_prev;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
                c = chk_q.pop_front();
                tests++;
                if (c.sel == SEL_TIMEOUT) begin
                    fails++;
                    $display("FAIL %s: got no host_ack within bound, required host_ack=1", c.name);
                end else if (c.cyc != cyc) begin
                    fails++;
                    $display("FAIL %s: sampled at cycle %0d, required cycle %0d", c.name, cyc, c.cyc);
                end else if (pick(c.sel) !== c.exp) begin
                    fails++;
                    $display("FAIL %s: got %h, required %h", c.name, pick(c.sel), c.exp);
                end
            end
            if (host_ack && !ack_prev) begin
                tests++;
                if (ack_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack: got host_ack=1 at cycle %0d, required 0", cyc);
                end else begin
                    a = ack_q.pop_front();
                    if (a.cyc != cyc) begin
                        fails++;
                        $display("FAIL %s: ack rose at cycle %0d, required cycle %0d", a.name, cyc, a.cyc);
                    end
                    if (a.chk_rd) begin
                        tests++;
                        if (host_rdata !== a.exp) begin
                            fails++;
                            $display("FAIL %s_rdata: got %h, required %h", a.name, host_rdata, a.exp);
                        end
                    end
                end
            end
            ack_prev = host_ack;
            if (done) begin
                tests++;
                if (chk_q.size() != 0 || ack_q.size() != 0) begin
                    fails++;
                    $display("FAIL queues_drained: got %0d checks/%0d acks pending, required 0/0",
                             chk_q.size(), ack_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string n, int s, logic [63:0] e);
        chk_q.push_back('{name: n, sel: s, exp: e, cyc: cyc});
    endtask

    task automatic start_req(bit we, int a, logic [63:0] d, int lat, bit chkrd,
                             logic [63:0] erd, string n);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a[ADDR_W-1:0];
        host_wdata = d;
        ack_q.push_back('{name: n, cyc: cyc + lat, chk_rd: chkrd, exp: erd});
    endtask

    task automatic wait_ack(string n);
        for (int i = 0; i < 20 && !host_ack; i++) begin
            step();
        end
        if (!host_ack) begin
            chk_q.push_back('{name: n, sel: SEL_TIMEOUT, exp: 64'd0, cyc: cyc});
        end
    endtask

    task automatic end_req(string n);
        host_req = 1'b0;
        chk({n, "_ack_held"}, SEL_ACK, 64'd1);
        step();
        chk({n, "_ack_fall"}, SEL_ACK, 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        wreg_en_wb   = 1'b0;
        wreg_addr_wb = '0;
        wdata_wb     = '0;
        raddr1       = '0;
        raddr2       = 3'd7;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_wdata   = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_count", SEL_COUNT, 64'd0);
        chk("rst_ack", SEL_ACK, 64'd0);
        chk("rst_hrdata", SEL_HRDATA, 64'd0);
        chk("rst_reg0", SEL_RDATA1, 64'd0);
        chk("rst_reg7", SEL_RDATA2, 64'd0);

        // Pipeline write with same-cycle bypass
        step();
        wreg_en_wb   = 1'b1;
        wreg_addr_wb = 3'd3;
        wdata_wb     = 64'hDEAD_BEEF_0000_0001;
        raddr1       = 3'd3;
        chk("wb_bypass", SEL_RDATA1, 64'hDEAD_BEEF_0000_0001);
        chk("wb_count_pre", SEL_COUNT, 64'd0);
        step();
        wreg_en_wb = 1'b0;
        wdata_wb   = '0;
        chk("wb_hold", SEL_RDATA1, 64'hDEAD_BEEF_0000_0001);
        chk("wb_count_1", SEL_COUNT, 64'd1);

        // Host write, writeback idle; later change to host_wdata must be ignored
        step();
        start_req(1'b1, 5, 64'h1234, 2, 1'b0, 64'd0, "host_wr");
        step();
        host_wdata = 64'hFFFF;
        wait_ack("host_wr_wait");
        end_req("host_wr");
        raddr2 = 3'd5;
        chk("host_wr_reg5", SEL_RDATA2, 64'h1234);
        chk("host_wr_count", SEL_COUNT, 64'd1);

        // Host write stalled by three writebacks to the same register
        start_req(1'b1, 2, 64'h55, 5, 1'b0, 64'd0, "stall_wr");
        step();
        wreg_en_wb   = 1'b1;
        wreg_addr_wb = 3'd2;
        wdata_wb     = 64'hAA;
        raddr1       = 3'd2;
        step();
        step();
        chk("stall_bypass", SEL_RDATA1, 64'hAA);
        chk("stall_ack_low", SEL_ACK, 64'd0);
        step();
        wreg_en_wb = 1'b0;
        chk("stall_pipe_val", SEL_RDATA1, 64'hAA);
        chk("stall_ack_low2", SEL_ACK, 64'd0);
        wait_ack("stall_wr_wait");
        chk("stall_host_wins", SEL_RDATA1, 64'h55);
        end_req("stall_wr");
        chk("stall_count", SEL_COUNT, 64'd4);

        // Host read bypassing a same-cycle pipeline write
        start_req(1'b0, 4, 64'd0, 2, 1'b1, 64'h77, "host_rd_byp");
        step();
        wreg_en_wb   = 1'b1;
        wreg_addr_wb = 3'd4;
        wdata_wb     = 64'h77;
        step();
        wreg_en_wb = 1'b0;
        wait_ack("host_rd_byp_wait");
        end_req("host_rd_byp");
        chk("host_rd_count", SEL_COUNT, 64'd5);

        // Counter wrap at CNT_W=4
        wreg_addr_wb = 3'd7;
        raddr1       = 3'd7;
        for (int i = 0; i < 10; i++) begin
            wreg_en_wb = 1'b1;
            wdata_wb   = 64'(i);
            step();
        end
        wreg_en_wb = 1'b0;
        chk("count_max", SEL_COUNT, 64'd15);
        wreg_en_wb = 1'b1;
        wdata_wb   = 64'h99;
        step();
        wreg_en_wb = 1'b0;
        chk("count_wrap", SEL_COUNT, 64'd0);
        chk("wrap_reg7", SEL_RDATA1, 64'h99);

        // Reset while a host write is stalled in EXEC
        step();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 3'd6;
        host_wdata = 64'h999;
        step();
        wreg_en_wb   = 1'b1;
        wreg_addr_wb = 3'd6;
        wdata_wb     = 64'h111;
        step();
        rst      = 1'b1;
        wdata_wb = 64'h222;
        step();
        rst        = 1'b0;
        wreg_en_wb = 1'b0;
        host_req   = 1'b0;
        chk("mid_rst_ack", SEL_ACK, 64'd0);
        chk("mid_rst_hrdata", SEL_HRDATA, 64'd0);
        chk("mid_rst_count", SEL_COUNT, 64'd0);
        for (int i = 0; i < 4; i++) begin
            raddr1 = 3'(2 * i);
            raddr2 = 3'(2 * i + 1);
            chk($sformatf("mid_rst_reg%0d", 2 * i), SEL_RDATA1, 64'd0);
            chk($sformatf("mid_rst_reg%0d", 2 * i + 1), SEL_RDATA2, 64'd0);
            step();
        end

        // Normal traffic after reset
        start_req(1'b1, 1, 64'hABC, 2, 1'b0, 64'd0, "post_rst_wr");
        step();
        wait_ack("post_rst_wr_wait");
        end_req("post_rst_wr");
        start_req(1'b0, 1, 64'd0, 2, 1'b1, 64'hABC, "post_rst_rd");
        step();
        wait_ack("post_rst_rd_wait");
        end_req("post_rst_rd");
        step();
        step();
        done = 1'b1;
    end

endmodule
